// File: rtl/i2c_reg_slave.sv
// I2C register slave: 16 x 8 register file behind an auto-incrementing
// 8-bit pointer, with synchronized and glitch-filtered bus inputs.
module i2c_reg_slave #(
   parameter logic [6:0] DEV_ADDR   = 7'h48,
   parameter int         GLITCH_CYC = 2
) (
   input  logic       clk_25M,
   input  logic       camera_rstn,
   input  logic       i2c_sclk,
   inout  wire        i2c_sdat,
   output logic       wr_strobe,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy
);

   localparam int CW = (GLITCH_CYC > 1) ? $clog2(GLITCH_CYC) : 1;

   typedef enum logic [3:0] {
      IDLE, DEV, ACK_DEV, REG, ACK_REG, WDATA, ACK_W, RDATA, MACK
   } state_t;

   // bit 0 = SCL, bit 1 = SDA
   logic [1:0]    s1, s2, filt, filt_q;
   logic [CW-1:0] gcnt [2];
   logic          armed;

   state_t        state;
   logic [3:0]    bitcnt;
   logic [7:0]    sr;
   logic [7:0]    ptr;
   logic [6:0]    tx;
   logic          rw;
   logic          sda_oe;
   logic [7:0]    regs [16];
   logic [7:0]    rd_byte;

   logic scl_rise, scl_fall, start_det, stop_det;

   assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;
   assign rd_data  = regs[rd_addr];
   assign rd_byte  = (ptr[7:4] == 4'd0) ? regs[ptr[3:0]] : 8'h00;

   assign scl_rise  = filt[0] & ~filt_q[0];
   assign scl_fall  = ~filt[0] & filt_q[0];
   assign start_det = armed & filt[0] & filt_q[0] & filt_q[1] & ~filt[1];
   assign stop_det  = armed & filt[0] & filt_q[0] & ~filt_q[1] & filt[1];

   always_ff @(posedge clk_25M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         s1     <= 2'b11;
         s2     <= 2'b11;
         filt   <= 2'b11;
         filt_q <= 2'b11;
         gcnt   <= '{default: '0};
         armed  <= 1'b0;
      end else begin
         s1     <= {i2c_sdat, i2c_sclk};
         s2     <= s1;
         filt_q <= filt;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] != filt[i]) begin
               if (gcnt[i] == CW'(GLITCH_CYC - 1)) begin
                  filt[i] <= s2[i];
                  gcnt[i] <= '0;
               end else begin
                  gcnt[i] <= gcnt[i] + 1'b1;
               end
            end else begin
               gcnt[i] <= '0;
            end
         end
         // Only trust edges once the pipeline holds real, idle bus levels
         if (s1 == 2'b11 && s2 == 2'b11 && filt == 2'b11)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk_25M or negedge camera_rstn) begin
      if (!camera_rstn) begin
         state     <= IDLE;
         bitcnt    <= 4'd0;
         sr        <= 8'h00;
         ptr       <= 8'h00;
         tx        <= 7'h00;
         rw        <= 1'b0;
         sda_oe    <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= 8'h00;
         wr_data   <= 8'h00;
         busy      <= 1'b0;
         for (int i = 0; i < 16; i++)
            regs[i] <= 8'h00;
      end else begin
         wr_strobe <= 1'b0;
         if (start_det) begin
            state  <= DEV;
            bitcnt <= 4'd0;
            sda_oe <= 1'b0;
            busy   <= 1'b1;
         end else if (stop_det) begin
            state  <= IDLE;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (scl_rise) begin
            unique case (state)
               DEV, REG, WDATA: begin
                  if (bitcnt < 4'd8) begin
                     sr     <= {sr[6:0], filt[1]};
                     bitcnt <= bitcnt + 4'd1;
                  end
               end
               MACK: begin
                  if (filt[1]) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
               default: ;
            endcase
         end else if (scl_fall) begin
            unique case (state)
               DEV: begin
                  if (bitcnt == 4'd8) begin
                     if (sr[7:1] == DEV_ADDR) begin
                        rw     <= sr[0];
                        sda_oe <= 1'b1;
                        state  <= ACK_DEV;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
               end
               ACK_DEV: begin
                  bitcnt <= 4'd0;
                  if (rw) begin
                     state  <= RDATA;
                     sda_oe <= ~rd_byte[7];
                     tx     <= rd_byte[6:0];
                  end else begin
                     state  <= REG;
                     sda_oe <= 1'b0;
                  end
               end
               REG: begin
                  if (bitcnt == 4'd8) begin
                     ptr    <= sr;
                     sda_oe <= 1'b1;
                     state  <= ACK_REG;
                  end
               end
               ACK_REG, ACK_W: begin
                  sda_oe <= 1'b0;
                  bitcnt <= 4'd0;
                  state  <= WDATA;
               end
               WDATA: begin
                  if (bitcnt == 4'd8) begin
                     sda_oe    <= 1'b1;
                     state     <= ACK_W;
                     wr_strobe <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= sr;
                     if (ptr[7:4] == 4'd0)
                        regs[ptr[3:0]] <= sr;
                     ptr <= ptr + 8'd1;
                  end
               end
               RDATA: begin
                  if (bitcnt == 4'd7) begin
                     sda_oe <= 1'b0;
                     state  <= MACK;
                     ptr    <= ptr + 8'd1;
                  end else begin
                     bitcnt <= bitcnt + 4'd1;
                     sda_oe <= ~tx[6];
                     tx     <= {tx[5:0], 1'b0};
                  end
               end
               MACK: begin
                  // a NACK already left on the rising edge
                  bitcnt <= 4'd0;
                  state  <= RDATA;
                  sda_oe <= ~rd_byte[7];
                  tx     <= rd_byte[6:0];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged master, strobe scoreboard,
// table of single-byte writes plus hand-written corner sequences.
module tb_i2c_reg_slave;

   logic       clk_25M;
   logic       camera_rstn;
   logic       scl;
   logic       m_low;
   logic [3:0] rd_addr;
   logic       wr_strobe;
   logic [7:0] wr_addr, wr_data, rd_data;
   logic       busy;
   wire        sda;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;

   i2c_reg_slave dut (
      .clk_25M    (clk_25M),
      .camera_rstn(camera_rstn),
      .i2c_sclk   (scl),
      .i2c_sdat   (sda),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy)
   );

   initial clk_25M = 1'b0;
   always #20 clk_25M = ~clk_25M;

   int n_chk = 0;
   int n_pass = 0;
   int drv_cnt = 0;
   logic [15:0] exp_q [$];
   logic [7:0]  mreg [16];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
      if (a < 8'd16) mreg[a[3:0]] = d;
   endtask

   // scoreboard: every strobe pops one expected write
   always @(negedge clk_25M) begin
      if (wr_strobe) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[15:8]});
            chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
         end
      end
   end

   // counts cycles where the slave pulls SDA low
   always @(negedge clk_25M)
      if (!m_low && sda === 1'b0) drv_cnt++;

   function automatic logic bus_sda();
      return (sda === 1'b0) ? 1'b0 : 1'b1;
   endfunction

   task automatic i2c_start();
      m_low = 1'b0;
      scl   = 1'b1;
      #400 m_low = 1'b1;
      #400 scl = 1'b0;
   endtask

   task automatic i2c_rstart();
      #400 m_low = 1'b0;
      #400 scl = 1'b1;
      #400 m_low = 1'b1;
      #400 scl = 1'b0;
   endtask

   task automatic i2c_stop();
      #400 m_low = 1'b1;
      #400 scl = 1'b1;
      #400 m_low = 1'b0;
      #800;
   endtask

   task automatic write_bit(input logic b, input logic g);
      #400 m_low = ~b;
      #400 scl = 1'b1;
      if (g) begin
         #200;
         @(negedge clk_25M) m_low = b;
         @(negedge clk_25M) m_low = ~b;
         #520;
      end else begin
         #800;
      end
      scl = 1'b0;
   endtask

   task automatic write_byte(input logic [7:0] b, input logic g,
                             output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(b[i], g);
      #400 m_low = 1'b0;
      #400 scl = 1'b1;
      #400 ack = ~bus_sda();
      #400 scl = 1'b0;
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d,
                            output logic s9);
      m_low = 1'b0;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #800 scl = 1'b1;
         #400 d = {d[6:0], bus_sda()};
         #400 scl = 1'b0;
      end
      #400 m_low = ~nack;
      #400 scl = 1'b1;
      #400 s9 = bus_sda();
      #400 scl = 1'b0;
      #400 m_low = 1'b0;
   endtask

   typedef struct {
      logic [7:0] dev;
      logic [7:0] ptr;
      logic [7:0] data;
      logic       ack;
      logic [3:0] ridx;
      logic [7:0] rexp;
   } vec_t;

   vec_t vt [5];

   initial begin
      logic       a;
      logic       s9;
      logic [7:0] d;

      vt[0] = '{8'h90, 8'h08, 8'hB1, 1'b1, 4'd8,  8'hB1};
      vt[1] = '{8'h90, 8'h00, 8'h5A, 1'b1, 4'd0,  8'h5A};
      vt[2] = '{8'h90, 8'h0F, 8'hC3, 1'b1, 4'd15, 8'hC3};
      vt[3] = '{8'h90, 8'h20, 8'h77, 1'b1, 4'd0,  8'h5A};
      vt[4] = '{8'h92, 8'h08, 8'h00, 1'b0, 4'd8,  8'hB1};
      for (int i = 0; i < 16; i++) mreg[i] = 8'h00;

      camera_rstn = 1'b0;
      scl = 1'b1;
      m_low = 1'b0;
      rd_addr = 4'd0;
      #200;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
      chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
      chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
      chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
      chk("rst_sda", {31'd0, bus_sda()}, 32'd1);
      @(negedge clk_25M) camera_rstn = 1'b1;
      #1000;

      for (int v = 0; v < 5; v++) begin
         drv_cnt = 0;
         i2c_start();
         write_byte(vt[v].dev, 1'b0, a);
         chk("dev_ack", {31'd0, a}, {31'd0, vt[v].ack});
         write_byte(vt[v].ptr, 1'b0, a);
         chk("ptr_ack", {31'd0, a}, {31'd0, vt[v].ack});
         if (vt[v].ack) push_exp(vt[v].ptr, vt[v].data);
         write_byte(vt[v].data, 1'b0, a);
         chk("data_ack", {31'd0, a}, {31'd0, vt[v].ack});
         i2c_stop();
         rd_addr = vt[v].ridx;
         #100;
         chk("vec_rd_data", {24'd0, rd_data}, {24'd0, vt[v].rexp});
         chk("vec_busy", {31'd0, busy}, 32'd0);
         chk("vec_q_empty", exp_q.size(), 32'd0);
         if (!vt[v].ack) chk("nack_no_drive", drv_cnt, 32'd0);
      end

      // pointer wrap 0xFF -> 0x00, out-of-range write ignored
      i2c_start();
      write_byte(8'h90, 1'b0, a);
      write_byte(8'hFF, 1'b0, a);
      push_exp(8'hFF, 8'h11);
      write_byte(8'h11, 1'b0, a);
      chk("wrap_ack_ff", {31'd0, a}, 32'd1);
      push_exp(8'h00, 8'h22);
      write_byte(8'h22, 1'b0, a);
      chk("wrap_ack_00", {31'd0, a}, 32'd1);
      i2c_stop();
      chk("wrap_q_empty", exp_q.size(), 32'd0);
      for (int i = 0; i < 16; i++) begin
         rd_addr = 4'(i);
         #1 chk($sformatf("reg%0d", i), {24'd0, rd_data}, {24'd0, mreg[i]});
      end

      // set pointer, repeated START, read two bytes
      i2c_start();
      write_byte(8'h90, 1'b0, a);
      write_byte(8'h08, 1'b0, a);
      i2c_rstart();
      write_byte(8'h91, 1'b0, a);
      chk("rd_dev_ack", {31'd0, a}, 32'd1);
      read_byte(1'b0, d, s9);
      chk("rd_byte0", {24'd0, d}, {24'd0, mreg[8]});
      read_byte(1'b1, d, s9);
      chk("rd_byte1", {24'd0, d}, {24'd0, mreg[9]});
      chk("rd_nack_sda", {31'd0, s9}, 32'd1);
      drv_cnt = 0;
      i2c_stop();
      chk("rd_no_drive", drv_cnt, 32'd0);
      chk("rd_busy", {31'd0, busy}, 32'd0);

      // STOP after 4 data bits
      i2c_start();
      write_byte(8'h90, 1'b0, a);
      write_byte(8'h03, 1'b0, a);
      for (int i = 0; i < 4; i++) write_bit(1'b1, 1'b0);
      i2c_stop();
      rd_addr = 4'd3;
      #100;
      chk("abort_reg3", {24'd0, rd_data}, {24'd0, mreg[3]});
      chk("abort_busy", {31'd0, busy}, 32'd0);

      // one-cycle glitches: idle, then on every bit of a data byte
      @(negedge clk_25M) m_low = 1'b1;
      @(negedge clk_25M) m_low = 1'b0;
      #1000;
      chk("glitch_idle_busy", {31'd0, busy}, 32'd0);
      i2c_start();
      write_byte(8'h90, 1'b0, a);
      write_byte(8'h05, 1'b0, a);
      push_exp(8'h05, 8'hA5);
      write_byte(8'hA5, 1'b1, a);
      chk("glitch_ack", {31'd0, a}, 32'd1);
      i2c_stop();
      rd_addr = 4'd5;
      #100;
      chk("glitch_reg5", {24'd0, rd_data}, 32'h0000_00A5);
      chk("glitch_q_empty", exp_q.size(), 32'd0);

      // reset pulse while the slave ACKs the address
      rd_addr = 4'd8;
      i2c_start();
      for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 4, 1'b0);
      #400 m_low = 1'b0;
      #400 scl = 1'b1;
      #400;
      chk("pre_rst_ack", {31'd0, bus_sda()}, 32'd0);
      camera_rstn = 1'b0;
      #1;
      chk("mid_rst_sda", {31'd0, bus_sda()}, 32'd1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_strobe", {31'd0, wr_strobe}, 32'd0);
      chk("mid_rst_addr", {24'd0, wr_addr}, 32'd0);
      chk("mid_rst_data", {24'd0, wr_data}, 32'd0);
      chk("mid_rst_reg8", {24'd0, rd_data}, 32'd0);
      for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
      #100 camera_rstn = 1'b1;
      #400 scl = 1'b0;
      drv_cnt = 0;
      write_byte(8'h90, 1'b0, a);
      write_byte(8'h08, 1'b0, a);
      i2c_stop();
      chk("post_rst_ignore", drv_cnt, 32'd0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      i2c_start();
      write_byte(8'h90, 1'b0, a);
      write_byte(8'h02, 1'b0, a);
      push_exp(8'h02, 8'h44);
      write_byte(8'h44, 1'b0, a);
      i2c_stop();
      rd_addr = 4'd2;
      #100;
      chk("recover_reg2", {24'd0, rd_data}, 32'h0000_0044);
      chk("final_q_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/i2c_reg_slave.md
I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter: DEV_ADDR, 7'h48, 7-bit I2C device address (write byte 0x90, read byte 0x91).
REQ-002 SHALL have parameter: GLITCH_CYC, 2, number of consecutive equal synchronized samples needed to accept an SCL/SDA level change.
REQ-003 SHALL have port: clk_25M  input  1  system clock, 25 MHz.
REQ-004 SHALL have port: camera_rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: i2c_sclk  input  1  I2C clock driven by the master; the block never drives it.
REQ-006 SHALL have port: i2c_sdat  inout  1  I2C data line, open-drain: the block drives 0 or high-Z, never 1.
REQ-007 SHALL have port: wr_strobe  output  1  one-cycle pulse on every accepted data-byte write.
REQ-008 SHALL have port: wr_addr  output  8  register pointer of the write flagged by wr_strobe.
REQ-009 SHALL have port: wr_data  output  8  data byte of the write flagged by wr_strobe.
REQ-010 SHALL have port: rd_addr  input  4  fabric-side read index into the register file.
REQ-011 SHALL have port: rd_data  output  8  combinational register-file contents at rd_addr.
REQ-012 SHALL have port: busy  output  1  high from a detected START until the state machine returns to IDLE.

Function
REQ-013 SHALL pass i2c_sclk and i2c_sdat through 2-FF synchronizers and a GLITCH_CYC filter before any edge detection.
REQ-014 SHALL detect START (incl. repeated START) as a filtered SDA fall while SCL is high, and STOP as a filtered SDA rise while SCL is high.
REQ-015 SHALL sample received bits on filtered SCL rising edges, MSB first.
REQ-016 SHALL change its SDA drive only within 4 clk_25M cycles after a filtered SCL falling edge.
REQ-017 SHALL implement states IDLE, DEV, ACK_DEV, REG, ACK_REG, WDATA, ACK_W, RDATA, MACK.
REQ-018 SHALL go IDLE->DEV on START; from any state, START SHALL go to DEV and STOP SHALL go to IDLE, even mid-byte.
REQ-019 SHALL, after 8 bits in DEV, ACK (drive SDA low for the 9th SCL period) only if bits[7:1]==DEV_ADDR; on mismatch, SHALL release SDA and return to IDLE.
REQ-020 SHALL, on address match, go to REG if R/W=0 and to RDATA if R/W=1.
REQ-021 SHALL, in REG, load the 8-bit pointer with the received byte, ACK, then enter WDATA.
REQ-022 SHALL, for each WDATA byte: ACK it; store it in reg[pointer] if pointer<16; pulse wr_strobe for exactly one cycle in the ACK period with wr_addr=pointer and wr_data=byte; then increment the pointer.
REQ-023 SHALL ACK writes with pointer>=16 and pulse wr_strobe, but leave the register file unchanged.
REQ-024 SHALL, in RDATA, drive reg[pointer] MSB first (0x00 if pointer>=16), then increment the pointer; it SHALL release SDA before the 9th SCL period.
REQ-025 SHALL sample the master's ACK in MACK: ACK (0) returns to RDATA with the next byte; NACK (1) returns to IDLE with SDA released.
REQ-026 SHALL increment the pointer modulo 256 (0xFF->0x00).
REQ-027 SHALL hold the register file as 16 x 8 bits; rd_data SHALL be reg[rd_addr].
REQ-028 SHALL preserve the pointer across repeated START so that a write-pointer/Sr/read sequence works.

Reset
REQ-029 SHALL, while camera_rstn=0, force: state IDLE, SDA released (high-Z), wr_strobe=0, wr_addr=0x00, wr_data=0x00, busy=0, pointer=0x00, all 16 registers=0x00, synchronizers=1.
REQ-030 SHALL, if reset is asserted mid-transfer, release SDA immediately and after release ignore the bus until the next START.

Verification
REQ-031 SHALL pass: START, 0x90, 0x08, 0xB1, STOP -> three ACKs; one wr_strobe with wr_addr=0x08, wr_data=0xB1; rd_addr=8 gives rd_data=0xB1.
REQ-032 SHALL pass: START, 0x92, 0x08 -> NACK on the first byte, SDA never driven afterward, no wr_strobe, busy returns to 0.
REQ-033 SHALL pass: START, 0x90, 0xFF, 0x11, 0x22, STOP -> two strobes, (0xFF,0x11) then (0x00,0x22); reg0=0x22; no register changed by the first write.
REQ-034 SHALL pass: after REQ-031, START, 0x90, 0x08, Sr, 0x91, read 2 bytes (master ACK, then NACK) -> returns 0xB1, then reg9=0x00; SDA released after the NACK.
REQ-035 SHALL pass: STOP after 4 bits of a data byte -> no strobe, IDLE; camera_rstn pulsed low during the ACK -> SDA released within 1 cycle and all outputs at reset values.
REQ-036 SHALL pass: 1-cycle SDA glitch while SCL is high -> no START/STOP detected, state unchanged.
